serial_word_collector: RTL

Downstream stage of the bit-serial increment unit. Samples its continuous LSB-first serial output, regroups it into `WORD_W`-bit parallel words on reset-aligned frame boundaries, and buffers them in a 2-entry FIFO behind a valid/ready handshake toward the parallel datapath. Words that complete while the FIFO is full are dropped and flagged.

---
 rtl/serial_word_collector.sv | 96 +++++++++
 1 files changed

// File: rtl/serial_word_collector.sv
// Regroups an LSB-first serial bit stream into WORD_W-bit words and queues them in a 2-entry FIFO.
// Optional saturating drop counter on port drop_cnt: define SWC_DROP_CNT_EN.
module serial_word_collector #(
  parameter int WORD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
`ifdef SWC_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

  logic [CW-1:0]     r_bit_cnt;
  logic [WORD_W-2:0] r_shreg;
  logic [WORD_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              r_overflow;

  logic [WORD_W-1:0] w_word;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;

  // The shift register only needs the upper WORD_W-1 bits of the frame; the
  // last bit is merged straight from the input in the completion cycle.
  assign w_word = {in, r_shreg};
  assign w_push = (r_bit_cnt == LAST);
  assign w_pop  = out_valid && out_ready;
  assign w_full = (r_count == 2'd2);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else begin
      r_bit_cnt <= (r_bit_cnt == LAST) ? '0 : r_bit_cnt + 1'b1;
      r_shreg   <= w_word[WORD_W-1:1];
    end
  end

  // When full, wptr equals rptr, so a push+pop overwrites the entry being popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_word;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count    <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
      r_overflow <= r_overflow | w_drop;
    end
  end

`ifdef SWC_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rptr];
  assign overflow  = r_overflow;

endmodule
